// File: rtl/pll_phase_rotate_responder_pkg.sv
// -----------------------------------------------------------------------------
// pll_phase_pkg
// Shared definitions for the PLL phase-rotation responder: output select
// indices, the rotation-request record carried through the latency pipe,
// the phase counter width and a modular step helper.
// -----------------------------------------------------------------------------
package pll_phase_pkg;

    localparam int PHASE_W = 7;   // counter width, wide enough for PHASE_MOD = 128
    localparam int NUM_OUT = 4;   // number of rotatable PLL outputs

    // Bit positions of each output in a select vector.
    localparam int SEL_BCLK   = 0;
    localparam int SEL_BCLK90 = 1;
    localparam int SEL_SCLK   = 2;
    localparam int SEL_MCLK   = 3;

    typedef logic [PHASE_W-1:0] phase_t;

    // One rotation request: direction (1 = increment) plus output selects.
    typedef struct packed {
        logic               dir;
        logic [NUM_OUT-1:0] sel;
    } rot_req_t;

    // Move a phase one step up or down; the mask (PHASE_MOD-1) gives the
    // wrap and keeps the bits above log2(PHASE_MOD) at zero.
    function automatic phase_t step_phase(input phase_t p, input logic up, input phase_t mask);
        return up ? ((p + phase_t'(1)) & mask) : ((p - phase_t'(1)) & mask);
    endfunction

endpackage

// File: rtl/pll_phase_rotate_responder_if.sv
// -----------------------------------------------------------------------------
// pll_phase_rotate_responder_if
// Phase-rotation port between the alignment trainer (master) and the PLL/IOG
// responder (slave).
//   master -> slave : loadphs_b, vcophsel_{bclk,bclk90,sclk,mclk}_sel,
//                     vcophsel_dir, vcophsel_rotate, reset_lane
//   slave -> master : bclk_igear_rx, {bclk,bclk90,sclk,mclk}_phase,
//                     rot_count, protocol_err
// -----------------------------------------------------------------------------
interface pll_phase_rotate_responder_if #(
    parameter int IOG_FABRIC_RATIO = 2
);
    import pll_phase_pkg::*;

    logic                        loadphs_b;
    logic                        vcophsel_bclk_sel;
    logic                        vcophsel_bclk90_sel;
    logic                        vcophsel_sclk_sel;
    logic                        vcophsel_mclk_sel;
    logic                        vcophsel_dir;
    logic                        vcophsel_rotate;
    logic                        reset_lane;
    logic [IOG_FABRIC_RATIO-1:0] bclk_igear_rx;
    phase_t                      bclk_phase;
    phase_t                      bclk90_phase;
    phase_t                      sclk_phase;
    phase_t                      mclk_phase;
    logic [15:0]                 rot_count;
    logic                        protocol_err;

    modport master (
        output loadphs_b, vcophsel_bclk_sel, vcophsel_bclk90_sel, vcophsel_sclk_sel,
               vcophsel_mclk_sel, vcophsel_dir, vcophsel_rotate, reset_lane,
        input  bclk_igear_rx, bclk_phase, bclk90_phase, sclk_phase, mclk_phase,
               rot_count, protocol_err
    );

    modport slave (
        input  loadphs_b, vcophsel_bclk_sel, vcophsel_bclk90_sel, vcophsel_sclk_sel,
               vcophsel_mclk_sel, vcophsel_dir, vcophsel_rotate, reset_lane,
        output bclk_igear_rx, bclk_phase, bclk90_phase, sclk_phase, mclk_phase,
               rot_count, protocol_err
    );

endinterface

// File: rtl/pll_rot_delay_line.sv
// -----------------------------------------------------------------------------
// pll_rot_delay_line
// Fixed-latency pipe for rotation requests, modelling the PLL response delay.
// A request pushed at edge N appears on valid_o/req_o after edge N+DEPTH-1, so
// the consumer applies it at edge N+DEPTH.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   flush_i      : synchronous discard of every pending request
//   push_i/req_i : enqueue one request this cycle
//   valid_o/req_o: request at the end of the pipe
// -----------------------------------------------------------------------------
module pll_rot_delay_line
    import pll_phase_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     flush_i,
    input  logic     push_i,
    input  rot_req_t req_i,
    output logic     valid_o,
    output rot_req_t req_o
);

    logic [DEPTH-1:0] valid_q;
    rot_req_t         req_q [DEPTH];

    // NOTE: sequential state is written with <= so every stage samples the
    // pre-edge value of its neighbour; blocking '=' would collapse the pipe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= push_i & ~flush_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1] & ~flush_i;
            end
        end
    end

    // NOTE: the payload is qualified by valid_q, so it carries no reset and
    // stays a plain shift register without reset fan-out.
    always_ff @(posedge clk_i) begin
        req_q[0] <= req_i;
        for (int i = 1; i < DEPTH; i++) begin
            req_q[i] <= req_q[i-1];
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign req_o   = req_q[DEPTH-1];

endmodule

// File: rtl/pll_phase_rotate_responder.sv
// -----------------------------------------------------------------------------
// pll_phase_rotate_responder
// PLL-side end of the dynamic phase-rotation port. Holds four output phase
// counters, applies load/rotate commands (rotations after ROT_LATENCY cycles),
// and returns the registered gearbox sample of BCLK as seen from SCLK.
//   sclk, reset : single rising-edge clock, asynchronous active-high reset
//   bus         : slave side of pll_phase_rotate_responder_if
// -----------------------------------------------------------------------------
module pll_phase_rotate_responder
    import pll_phase_pkg::*;
#(
    parameter int IOG_FABRIC_RATIO = 2,
    parameter int PHASE_MOD        = 64,
    parameter int EDGE_PHASE       = 20,
    parameter int INIT_PHASE       = 0,
    parameter int ROT_LATENCY      = 3
) (
    input  logic                          sclk,
    input  logic                          reset,
    pll_phase_rotate_responder_if.slave   bus
);

    localparam phase_t MASK   = phase_t'(PHASE_MOD - 1);
    localparam phase_t HALF   = phase_t'(PHASE_MOD / 2);
    localparam phase_t EDGE_P = phase_t'(EDGE_PHASE % PHASE_MOD);
    localparam phase_t INIT_P = phase_t'(INIT_PHASE % PHASE_MOD);

    logic [NUM_OUT-1:0][PHASE_W-1:0] phase_q, phase_d;
    logic [15:0]                     rot_count_q, rot_count_d;
    logic                            err_q, err_d;
    logic [IOG_FABRIC_RATIO-1:0]     word_q, word_d;
    logic [1:0]                      hold_q, hold_d;

    logic [NUM_OUT-1:0] sel_now;
    logic               load;
    rot_req_t           push_req, due_req;
    logic               due_valid;

    assign sel_now  = {bus.vcophsel_mclk_sel, bus.vcophsel_sclk_sel,
                       bus.vcophsel_bclk90_sel, bus.vcophsel_bclk_sel};
    assign load     = ~bus.loadphs_b;
    assign push_req = '{dir: bus.vcophsel_dir, sel: sel_now};

    // A load both blocks the push (load wins over a same-cycle rotate) and
    // flushes everything still in flight, including an entry maturing now.
    pll_rot_delay_line #(.DEPTH(ROT_LATENCY)) u_delay (
        .clk_i   (sclk),
        .rst_i   (reset),
        .flush_i (load),
        .push_i  (bus.vcophsel_rotate & ~load),
        .req_i   (push_req),
        .valid_o (due_valid),
        .req_o   (due_req)
    );

    // Bit i is high when SCLK-relative BCLK phase, advanced by i steps, lies in
    // the high half-period starting at EDGE_PHASE (all arithmetic mod PHASE_MOD).
    function automatic logic [IOG_FABRIC_RATIO-1:0] gen_word(input phase_t b, input phase_t s);
        phase_t rel, pos, off;
        gen_word = '0;
        rel = (b - s) & MASK;
        for (int i = 0; i < IOG_FABRIC_RATIO; i++) begin
            pos = (rel + phase_t'(i)) & MASK;
            off = (pos - EDGE_P) & MASK;
            gen_word[i] = (off < HALF);
        end
    endfunction

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        phase_d     = phase_q;
        rot_count_d = rot_count_q;
        err_d       = err_q | (load & bus.vcophsel_rotate);
        hold_d      = hold_q;
        word_d      = '0;

        if (load) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (sel_now[i]) phase_d[i] = INIT_P;
            end
        end else if (due_valid) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (due_req.sel[i]) phase_d[i] = step_phase(phase_q[i], due_req.dir, MASK);
            end
            if (rot_count_q != 16'hFFFF) rot_count_d = rot_count_q + 16'd1;
        end

        // Word is forced low while the lane is in reset and for two edges after.
        if (bus.reset_lane) begin
            hold_d = 2'd2;
        end else if (hold_q != 2'd0) begin
            hold_d = hold_q - 2'd1;
        end
        if (!bus.reset_lane && hold_q == 2'd0) begin
            word_d = gen_word(phase_q[SEL_BCLK], phase_q[SEL_SCLK]);
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            rot_count_q <= '0;
            err_q       <= 1'b0;
            word_q      <= '0;
            hold_q      <= '0;
        end else begin
            phase_q     <= phase_d;
            rot_count_q <= rot_count_d;
            err_q       <= err_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
        end
    end

    assign bus.bclk_phase    = phase_q[SEL_BCLK];
    assign bus.bclk90_phase  = phase_q[SEL_BCLK90];
    assign bus.sclk_phase    = phase_q[SEL_SCLK];
    assign bus.mclk_phase    = phase_q[SEL_MCLK];
    assign bus.rot_count     = rot_count_q;
    assign bus.protocol_err  = err_q;
    assign bus.bclk_igear_rx = word_q;

endmodule

// File: tb/tb_pll_phase_rotate_responder.sv
// -----------------------------------------------------------------------------
// tb_pll_phase_rotate_responder
// Directed bench for pll_phase_rotate_responder with a cycle-level reference
// model (pending-request queue with due cycles) compared on every falling edge,
// plus literal expectations at the scenario boundaries.
// -----------------------------------------------------------------------------
module tb_pll_phase_rotate_responder;
    import pll_phase_pkg::*;

    localparam int R    = 2;
    localparam int M    = 64;
    localparam int E    = 20;
    localparam int INIT = 0;
    localparam int L    = 3;

    logic sclk  = 1'b0;
    logic reset = 1'b1;
    always #5 sclk = ~sclk;

    pll_phase_rotate_responder_if #(.IOG_FABRIC_RATIO(R)) bus ();

    pll_phase_rotate_responder #(
        .IOG_FABRIC_RATIO (R),
        .PHASE_MOD        (M),
        .EDGE_PHASE       (E),
        .INIT_PHASE       (INIT),
        .ROT_LATENCY      (L)
    ) dut (
        .sclk  (sclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int       due;
        bit       dir;
        bit [3:0] sel;
    } pend_t;

    pend_t      pend[$];
    int         m_ph[4];
    int         m_cnt     = 0;
    bit         m_err     = 1'b0;
    bit [R-1:0] m_word    = '0;
    int         m_cyc     = 0;
    int         m_last_rl = -100;
    bit [3:0]   m_sel;

    // Spec rule taken literally: enumerate the high half-period window.
    function automatic bit [R-1:0] model_word(input int b, input int s);
        int rel, pos;
        bit [R-1:0] w;
        w = '0;
        rel = ((b - s) % M + M) % M;
        for (int i = 0; i < R; i++) begin
            pos = (rel + i) % M;
            for (int k = 0; k < M / 2; k++) begin
                if ((E + k) % M == pos) w[i] = 1'b1;
            end
        end
        return w;
    endfunction

    always @(posedge sclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_ph[i] = 0;
            m_cnt = 0;
            m_err = 1'b0;
            m_word = '0;
            m_last_rl = -100;
            pend.delete();
        end else begin
            m_cyc++;
            m_sel = {bus.vcophsel_mclk_sel, bus.vcophsel_sclk_sel,
                     bus.vcophsel_bclk90_sel, bus.vcophsel_bclk_sel};
            if (bus.reset_lane) m_last_rl = m_cyc;
            m_word = (m_cyc - m_last_rl <= 2) ? '0 : model_word(m_ph[0], m_ph[2]);
            if (!bus.loadphs_b) begin
                pend.delete();
                for (int i = 0; i < 4; i++) if (m_sel[i]) m_ph[i] = INIT;
                if (bus.vcophsel_rotate) m_err = 1'b1;
            end else begin
                for (int k = pend.size() - 1; k >= 0; k--) begin
                    if (pend[k].due == m_cyc) begin
                        for (int i = 0; i < 4; i++) begin
                            if (pend[k].sel[i])
                                m_ph[i] = pend[k].dir ? (m_ph[i] + 1) % M : (m_ph[i] + M - 1) % M;
                        end
                        if (m_cnt < 65535) m_cnt++;
                        pend.delete(k);
                    end
                end
                if (bus.vcophsel_rotate) pend.push_back('{m_cyc + L, bus.vcophsel_dir, m_sel});
            end
        end
    end

    always @(negedge sclk) begin
        check("cmp_bclk_phase",   bus.bclk_phase,    m_ph[0]);
        check("cmp_bclk90_phase", bus.bclk90_phase,  m_ph[1]);
        check("cmp_sclk_phase",   bus.sclk_phase,    m_ph[2]);
        check("cmp_mclk_phase",   bus.mclk_phase,    m_ph[3]);
        check("cmp_rot_count",    bus.rot_count,     m_cnt);
        check("cmp_protocol_err", bus.protocol_err,  m_err);
        check("cmp_word",         bus.bclk_igear_rx, m_word);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic set_sel(input logic [3:0] sel);
        bus.vcophsel_bclk_sel   = sel[0];
        bus.vcophsel_bclk90_sel = sel[1];
        bus.vcophsel_sclk_sel   = sel[2];
        bus.vcophsel_mclk_sel   = sel[3];
    endtask

    task automatic idle();
        bus.loadphs_b       = 1'b1;
        bus.vcophsel_rotate = 1'b0;
        bus.vcophsel_dir    = 1'b0;
        set_sel(4'b0000);
    endtask

    task automatic do_load(input logic [3:0] sel);
        bus.loadphs_b = 1'b0;
        set_sel(sel);
        cycles(1);
        idle();
    endtask

    // n back-to-back rotate requests, one per cycle.
    task automatic rot_n(input int n, input logic dir, input logic [3:0] sel);
        bus.vcophsel_rotate = 1'b1;
        bus.vcophsel_dir    = dir;
        set_sel(sel);
        cycles(n);
        idle();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle();
        bus.reset_lane = 1'b0;
        cycles(3);
        check("rst_bclk_phase", bus.bclk_phase, 0);
        check("rst_word",       bus.bclk_igear_rx, 0);
        check("rst_rot_count",  bus.rot_count, 0);
        check("rst_err",        bus.protocol_err, 0);
        reset = 1'b0;
        cycles(2);

        // Sweep: 19 increments, then a 20th crossing the sampling edge.
        do_load(4'b0001);
        rot_n(19, 1'b1, 4'b0001);
        cycles(2);
        check("sweep_phase18", bus.bclk_phase, 18);
        cycles(1);
        check("sweep_phase19", bus.bclk_phase, 19);
        check("sweep_count19", bus.rot_count, 19);
        cycles(1);
        check("sweep_word19", bus.bclk_igear_rx, 2'b10);
        rot_n(1, 1'b1, 4'b0001);
        cycles(2);
        check("sweep_phase_pending", bus.bclk_phase, 19);
        cycles(1);
        check("sweep_phase20", bus.bclk_phase, 20);
        check("sweep_word_lag", bus.bclk_igear_rx, 2'b10);
        cycles(1);
        check("sweep_word20", bus.bclk_igear_rx, 2'b11);

        // Wrap in both directions.
        rot_n(43, 1'b1, 4'b0001);
        cycles(L);
        check("wrap_phase63", bus.bclk_phase, 63);
        rot_n(1, 1'b1, 4'b0001);
        cycles(L);
        check("wrap_up_to0", bus.bclk_phase, 0);
        rot_n(1, 1'b0, 4'b0001);
        cycles(L);
        check("wrap_down_to63", bus.bclk_phase, 63);
        rot_n(1, 1'b0, 4'b1010);
        cycles(L);
        check("wrap_bclk90", bus.bclk90_phase, 63);
        check("wrap_mclk",   bus.mclk_phase, 63);
        check("wrap_count",  bus.rot_count, 66);

        // Flush: the first request matures on the load edge and is discarded.
        rot_n(2, 1'b1, 4'b0001);
        cycles(1);
        do_load(4'b0001);
        check("flush_phase", bus.bclk_phase, INIT);
        check("flush_count", bus.rot_count, 66);
        cycles(5);
        check("flush_phase_later", bus.bclk_phase, INIT);
        check("flush_count_later", bus.rot_count, 66);

        // Lane reset with rel = 0 - 34 = 30 mod 64.
        rot_n(30, 1'b0, 4'b0100);
        cycles(5);
        check("lane_sclk_phase", bus.sclk_phase, 34);
        check("lane_word_pre", bus.bclk_igear_rx, 2'b11);
        bus.reset_lane = 1'b1;
        cycles(1);
        check("lane_word_hold0", bus.bclk_igear_rx, 2'b00);
        cycles(4);
        bus.reset_lane = 1'b0;
        check("lane_word_hold4", bus.bclk_igear_rx, 2'b00);
        cycles(1);
        check("lane_word_tail1", bus.bclk_igear_rx, 2'b00);
        cycles(1);
        check("lane_word_tail2", bus.bclk_igear_rx, 2'b00);
        cycles(1);
        check("lane_word_back", bus.bclk_igear_rx, 2'b11);

        // Protocol error: rotate alongside load.
        bus.loadphs_b       = 1'b0;
        bus.vcophsel_rotate = 1'b1;
        bus.vcophsel_dir    = 1'b1;
        set_sel(4'b0001);
        cycles(1);
        idle();
        check("err_set", bus.protocol_err, 1);
        cycles(5);
        check("err_phase", bus.bclk_phase, INIT);
        check("err_count", bus.rot_count, 96);
        check("err_sticky", bus.protocol_err, 1);

        // Mid-run reset with rotations in flight.
        rot_n(2, 1'b1, 4'b0001);
        reset = 1'b1;
        #2;
        check("mrst_count_async", bus.rot_count, 0);
        check("mrst_err_async", bus.protocol_err, 0);
        check("mrst_sclk_async", bus.sclk_phase, 0);
        cycles(2);
        reset = 1'b0;
        cycles(6);
        check("mrst_phase", bus.bclk_phase, 0);
        check("mrst_count", bus.rot_count, 0);
        check("mrst_word",  bus.bclk_igear_rx, 2'b00);

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_phase_rotate_responder.md
# pll_phase_rotate_responder

Synthesizable responder for the PLL dynamic phase-rotation interface; it acts as the PLL/IOG end that the BCLK/SCLK alignment trainer drives. It accepts `loadphs_b`/`vcophsel_*`/`vcophsel_rotate` commands, applies them to per-output phase counters after a fixed PLL latency, and returns the gearbox-sampled BCLK word `bclk_igear_rx`. It sits in the training-loop emulation harness and in hardware bring-up builds where the real PLL phase port is stubbed.

## Interface
- `IOG_FABRIC_RATIO`, 2, width of the sampled BCLK word (2 or 4 only)
- `PHASE_MOD`, 64, phase steps per BCLK period (power of 2, 8..128)
- `EDGE_PHASE`, 20, relative phase at which the sampled BCLK rises
- `INIT_PHASE`, 0, value loaded into every selected counter on load
- `ROT_LATENCY`, 3, cycles from rotate request to phase change (1..8)
- `sclk` in 1: single clock, all logic rising-edge
- `reset` in 1: asynchronous, active-high
- `loadphs_b` in 1: active-low load strobe
- `vcophsel_bclk_sel`, `vcophsel_bclk90_sel`, `vcophsel_sclk_sel`, `vcophsel_mclk_sel` in 1 each: output selects
- `vcophsel_dir` in 1: 1 = increment, 0 = decrement
- `vcophsel_rotate` in 1: one rotation request per cycle high
- `reset_lane` in 1: gearbox lane reset
- `bclk_igear_rx` out IOG_FABRIC_RATIO: sampled BCLK word
- `bclk_phase`, `bclk90_phase`, `sclk_phase`, `mclk_phase` out 7: current phase counters
- `rot_count` out 16: total applied rotations, saturating at 16'hFFFF
- `protocol_err` out 1: sticky error flag

## Operation
- Reset values: all phase counters = 0, `bclk_igear_rx` = 0, `rot_count` = 0, `protocol_err` = 0, and the delay line is empty.
- Load: `loadphs_b` = 0 sets every counter whose select is high to INIT_PHASE on the next edge. Load also flushes the delay line, discarding pending rotations. Load with no select high is a no-op, and the flush still occurs.
- Rotate: each cycle with `vcophsel_rotate` = 1 pushes {dir, 4 selects} into the ROT_LATENCY-deep delay line.
  - Exactly ROT_LATENCY cycles later, each selected counter moves ±1 modulo PHASE_MOD, and `rot_count` increments by 1.
  - Back-to-back requests are all honoured, one per cycle.
  - A rotate with no select high is still counted, with no phase change.
- Wrap: an increment from PHASE_MOD-1 goes to 0; a decrement from 0 goes to PHASE_MOD-1. Counters are 7-bit, and bits above log2(PHASE_MOD) stay 0.
- Sampled word: rel = (bclk_phase − sclk_phase) mod PHASE_MOD. Bit i = 1 iff ((rel + i) mod PHASE_MOD) is within [EDGE_PHASE, EDGE_PHASE + PHASE_MOD/2), computed with wrap.
- Lane reset: while `reset_lane` = 1, and for 2 cycles after it falls, `bclk_igear_rx` = 0.
- Errors: `rotate` = 1 in the same cycle as `loadphs_b` = 0 sets `protocol_err`. In that case load wins and the request is not pushed. `protocol_err` clears only on `reset`.
- `reset` asserted mid-operation returns all state to reset values immediately and drops pending rotations.

## Timing
- Rotate sampled at edge N changes the phase counter at edge N+ROT_LATENCY. The matching `bclk_igear_rx` updates at edge N+ROT_LATENCY+1.
- Load at edge N: counter = INIT_PHASE after edge N, word reflects it after edge N+1.
- If a delay-line entry matures in the same cycle as a load, load wins and the entry is discarded.
- `bclk_igear_rx` is registered, 1 cycle after the counters. The phase outputs and `rot_count` are direct register outputs.

## Structure
- Shared package `pll_phase_pkg`:
  - select-index constants: BCLK = 0, BCLK90 = 1, SCLK = 2, MCLK = 3
  - rotation-request struct {dir, sel[3:0]}
  - PHASE_W = 7
- Sub-module `pll_rot_delay_line`: parameterized shift register of valid and request bits, with synchronous flush and async reset.
- Top level holds the four counters, the word generator, the lane-reset hold counter and the error/status logic.

## Test plan
All scenarios use the defaults (R = 2, PHASE_MOD = 64, EDGE_PHASE = 20, ROT_LATENCY = 3).
- Reset: assert `reset` mid-run → all phases 0, `bclk_igear_rx` = 2'b00, `rot_count` = 0, `protocol_err` = 0.
- Sweep: load, then 19 rotates with bclk_sel = 1, dir = 1 → after latency, `bclk_phase` = 19 and word = 2'b10. One more rotate → phase 20, word = 2'b11 exactly 4 cycles after the request.
- Wrap: walk `bclk_phase` to 63, rotate up → 0; rotate down → 63; `rot_count` reflects every request.
- Flush: issue 2 rotates, then load 1 cycle later → neither applies, phase = INIT_PHASE, `rot_count` unchanged.
- Lane reset: `reset_lane` held for 5 cycles with rel = 30 → word 00 during the pulse plus 2 cycles, then 2'b11.
- Error: rotate with `loadphs_b` = 0 → `protocol_err` = 1 and stays set, phase = INIT_PHASE, no rotation applied.
